// File: rtl/osc_tick_gen.sv
// Multi-channel clock-enable generator: per-channel runtime divider producing a one-cycle TICK
// and a registered divided waveform, with shadowed glitch-free reload and global resync.
module osc_tick_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_CH-1:0]    EN,
  input  logic [NUM_CH-1:0]    DIV_LOAD,
  input  logic [DIV_WIDTH-1:0] DIV_VALUE,
  input  logic                 SYNC,
  output logic [NUM_CH-1:0]    TICK,
  output logic [NUM_CH-1:0]    CLK_DIV,
  output logic [NUM_CH-1:0]    LOAD_PENDING
);

  typedef logic [DIV_WIDTH-1:0] div_t;

  localparam div_t DefDiv = div_t'(DEFAULT_DIV);
  localparam div_t One    = div_t'(1);

  div_t              cnt_q [NUM_CH];
  div_t              cnt_d [NUM_CH];
  div_t              div_q [NUM_CH];
  div_t              div_d [NUM_CH];
  div_t              shd_q [NUM_CH];
  div_t              shd_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] clkd_q, clkd_d;

  // Length of the high phase: ceil(d/2), so odd dividers get the extra cycle high.
  function automatic div_t half_up(input div_t d);
    return (d >> 1) + div_t'(d[0]);
  endfunction

  // The shadow always equals the active divider unless a load is pending, so every
  // "apply" path can simply take the next shadow value.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shd_d[i]  = DIV_LOAD[i] ? DIV_VALUE : shd_q[i];
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pend_d[i] = pend_q[i];
      tick_d[i] = 1'b0;
      clkd_d[i] = clkd_q[i];

      if (SYNC) begin
        cnt_d[i]  = '0;
        div_d[i]  = shd_d[i];
        pend_d[i] = 1'b0;
        clkd_d[i] = (shd_d[i] != '0);
      end else if (DIV_LOAD[i] && (!EN[i] || (div_q[i] == '0))) begin
        // Idle or halted channel: nothing to glitch, apply at once and restart.
        cnt_d[i]  = '0;
        div_d[i]  = DIV_VALUE;
        pend_d[i] = 1'b0;
        clkd_d[i] = (DIV_VALUE != '0);
      end else if (div_q[i] == '0) begin
        cnt_d[i]  = '0;
        clkd_d[i] = 1'b0;
      end else if (EN[i]) begin
        if (cnt_q[i] == (div_q[i] - One)) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          div_d[i]  = shd_d[i];
          pend_d[i] = 1'b0;
          clkd_d[i] = (shd_d[i] != '0);
        end else begin
          cnt_d[i]  = cnt_q[i] + One;
          pend_d[i] = pend_q[i] | DIV_LOAD[i];
          clkd_d[i] = ((cnt_q[i] + One) < half_up(div_q[i]));
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DefDiv;
        shd_q[i] <= DefDiv;
      end
      pend_q <= '0;
      tick_q <= '0;
      clkd_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
        shd_q[i] <= shd_d[i];
      end
      pend_q <= pend_d;
      tick_q <= tick_d;
      clkd_q <= clkd_d;
    end
  end

  assign TICK         = tick_q;
  assign CLK_DIV      = clkd_q;
  assign LOAD_PENDING = pend_q;

endmodule

// File: tb/tb_osc_tick_gen.sv
// Directed, table-driven bench for osc_tick_gen (4 channels, 16-bit dividers, reset divide 2),
// plus hand-written sequences for pending-load overwrite and reload timing.
module tb_osc_tick_gen;

  logic        CLK;
  logic        RESET;
  logic [3:0]  EN;
  logic [3:0]  DIV_LOAD;
  logic [15:0] DIV_VALUE;
  logic        SYNC;
  logic [3:0]  TICK;
  logic [3:0]  CLK_DIV;
  logic [3:0]  LOAD_PENDING;

  int n_checks = 0;
  int n_fail   = 0;

  osc_tick_gen #(
    .NUM_CH     (4),
    .DIV_WIDTH  (16),
    .DEFAULT_DIV(2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .EN          (EN),
    .DIV_LOAD    (DIV_LOAD),
    .DIV_VALUE   (DIV_VALUE),
    .SYNC        (SYNC),
    .TICK        (TICK),
    .CLK_DIV     (CLK_DIV),
    .LOAD_PENDING(LOAD_PENDING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        sync;
    logic [3:0]  en;
    logic [3:0]  load;
    logic [15:0] val;
    logic [3:0]  tick;
    logic [3:0]  clkd;
    logic [3:0]  pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void row(input logic rst, input logic sync, input logic [3:0] en,
                              input logic [3:0] load, input logic [15:0] val,
                              input logic [3:0] tick, input logic [3:0] clkd,
                              input logic [3:0] pend);
    vec_t t;
    t.rst  = rst;
    t.sync = sync;
    t.en   = en;
    t.load = load;
    t.val  = val;
    t.tick = tick;
    t.clkd = clkd;
    t.pend = pend;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  // Count edges until ch0 ticks; -1 if the budget runs out.
  task automatic wait_tick0(input int max_cycles, output int n);
    n = -1;
    for (int k = 1; k <= max_cycles; k++) begin
      @(posedge CLK);
      #1;
      if (TICK[0] === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    RESET     = 1'b1;
    SYNC      = 1'b0;
    EN        = 4'hF;
    DIV_LOAD  = 4'h0;
    DIV_VALUE = 16'd0;

    //   rst  sync en       load     val  tick     clkd     pend
    row(1'b1, 1'b0, 4'hF,   4'h0,    0,   4'b0000, 4'b0000, 4'b0000); // 0 reset
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0000, 4'b0000, 4'b0000); // 1
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b1111, 4'b1111, 4'b0000); // 2 first wrap
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0000, 4'b0000, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b1111, 4'b1111, 4'b0000); // 4
    row(1'b0, 1'b0, 4'hF,   4'b0001, 5,   4'b0000, 4'b0000, 4'b0001); // 5 ch0 load 5 pends
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b1111, 4'b1111, 4'b0000); // 6 applied at wrap
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0000, 4'b0001, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b1110, 4'b1111, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0000, 4'b0000, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b1110, 4'b1110, 4'b0000); // 10
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0001, 4'b0001, 4'b0000); // 11 ch0 period 5
    row(1'b0, 1'b0, 4'hF,   4'b0010, 3,   4'b1110, 4'b1111, 4'b0000); // 12 ch1 load on wrap
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0000, 4'b0011, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b1100, 4'b1100, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0010, 4'b0010, 4'b0000); // 15 ch1 period 3
    row(1'b0, 1'b0, 4'b1011, 4'b0100, 0,  4'b1001, 4'b1011, 4'b0000); // 16 ch2 load 0, EN off
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0000, 4'b0001, 4'b0000); // 17 ch2 halted
    row(1'b0, 1'b0, 4'hF,   4'b0100, 1,   4'b1010, 4'b1111, 4'b0000); // 18 ch2 load 1
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0100, 4'b0110, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b1100, 4'b1100, 4'b0000); // 20
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0111, 4'b0111, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'b1000, 4,   4'b1100, 4'b1111, 4'b0000); // 22 ch3 D=4
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0100, 4'b1101, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0110, 4'b0110, 4'b0000); // 24 ch3 cnt=2
    row(1'b0, 1'b0, 4'b0111, 4'h0,   0,   4'b0100, 4'b0110, 4'b0000); // 25 ch3 held
    row(1'b0, 1'b0, 4'b0111, 4'h0,   0,   4'b0101, 4'b0101, 4'b0000);
    row(1'b0, 1'b0, 4'b0111, 4'h0,   0,   4'b0110, 4'b0111, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0100, 4'b0111, 4'b0000); // 28 ch3 cnt=3
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b1100, 4'b1100, 4'b0000); // 29 ch3 wraps
    row(1'b0, 1'b0, 4'hF,   4'b0001, 6,   4'b0110, 4'b1110, 4'b0001); // 30 ch0 load 6 pends
    row(1'b0, 1'b1, 4'hF,   4'h0,    0,   4'b0000, 4'b1111, 4'b0000); // 31 SYNC
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0100, 4'b1111, 4'b0000);
    row(1'b1, 1'b0, 4'hF,   4'b0010, 7,   4'b0000, 4'b0000, 4'b0000); // 33 reset beats load
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b0000, 4'b0000, 4'b0000);
    row(1'b0, 1'b0, 4'hF,   4'h0,    0,   4'b1111, 4'b1111, 4'b0000); // 35 back to D=2

    foreach (vecs[i]) begin
      @(negedge CLK);
      RESET     = vecs[i].rst;
      SYNC      = vecs[i].sync;
      EN        = vecs[i].en;
      DIV_LOAD  = vecs[i].load;
      DIV_VALUE = vecs[i].val;
      @(posedge CLK);
      #1;
      chk("tick", i, 32'(TICK), 32'(vecs[i].tick));
      chk("clk_div", i, 32'(CLK_DIV), 32'(vecs[i].clkd));
      chk("load_pending", i, 32'(LOAD_PENDING), 32'(vecs[i].pend));
    end

    // ch0: immediate load of 8 while idle, then two back-to-back loads while pending.
    @(negedge CLK);
    RESET = 1'b0; SYNC = 1'b0; EN = 4'b0000; DIV_LOAD = 4'b0001; DIV_VALUE = 16'd8;
    @(posedge CLK); #1;
    chk("idle_load_pend", 100, 32'(LOAD_PENDING[0]), 32'd0);
    chk("idle_load_tick", 100, 32'(TICK[0]), 32'd0);
    @(negedge CLK);
    EN = 4'b0001; DIV_LOAD = 4'b0000;
    @(posedge CLK); #1;                                    // cnt 1
    @(negedge CLK);
    DIV_LOAD = 4'b0001; DIV_VALUE = 16'd3;
    @(posedge CLK); #1;                                    // cnt 2, pending 3
    chk("pend_first", 101, 32'(LOAD_PENDING[0]), 32'd1);
    @(negedge CLK);
    DIV_VALUE = 16'd4;
    @(posedge CLK); #1;                                    // cnt 3, pending 4
    chk("pend_overwrite", 102, 32'(LOAD_PENDING[0]), 32'd1);
    chk("no_early_tick", 102, 32'(TICK[0]), 32'd0);
    @(negedge CLK);
    DIV_LOAD = 4'b0000;
    wait_tick0(20, n);
    chk("wrap_at_old_div", 103, 32'(n), 32'd5);
    chk("pend_cleared", 103, 32'(LOAD_PENDING[0]), 32'd0);
    wait_tick0(20, n);
    chk("last_load_wins", 104, 32'(n), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
